// File: rtl/pro_ele_array.sv
// pro_ele_array: LANES fixed-point MAC neurons sharing one x stream.
// Define PRO_ELE_RELU_EN to clamp negative results to zero.
module pro_ele_array #(
  parameter int DW    = 16,
  parameter int FRAC  = 8,
  parameter int LANES = 4,
  parameter int CNT_W = 10,
  parameter int ACC_W = 2*DW+CNT_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  head,
  input  logic                  in_valid,
  input  logic [DW-1:0]         x_in,
  input  logic [LANES*DW-1:0]   w,
  input  logic [LANES*DW-1:0]   b,
  input  logic                  out_ready,
  output logic [LANES*DW-1:0]   pe_out,
  output logic                  done_flag,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    BIAS,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0] fin_cnt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             last;

  logic signed [2*DW-1:0]  xe;
  logic signed [2*DW-1:0]  we   [LANES];
  logic signed [2*DW-1:0]  prod [LANES];
  logic signed [ACC_W-1:0] acc  [LANES];
  logic signed [ACC_W-1:0] bsum [LANES];
  logic signed [ACC_W-1:0] shr  [LANES];
  logic [ACC_W-DW:0]       top  [LANES];
  logic [DW-1:0]           res  [LANES];

  localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

  assign cnt_inc   = cnt + 1'b1;
  assign last      = in_valid && (cnt_inc == fin_cnt);
  assign busy      = (state != IDLE);
  assign done_flag = (state == DONE);

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (head)
          state_nx = (x_in[CNT_W-1:0] == '0) ? BIAS : ACCUM;
      end
      ACCUM: begin
        if (last) state_nx = BIAS;
      end
      BIAS: state_nx = DONE;
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
    endcase
  end

  // Per-lane product, bias add, floor shift and saturation
  always_comb begin
    xe = {{DW{x_in[DW-1]}}, x_in};
    for (int i = 0; i < LANES; i++) begin
      we[i]   = {{DW{w[i*DW+DW-1]}}, w[i*DW +: DW]};
      prod[i] = xe * we[i];
      bsum[i] = acc[i]
              + ({{(ACC_W-DW){b[i*DW+DW-1]}}, b[i*DW +: DW]} << FRAC);
      shr[i]  = bsum[i] >>> FRAC;
      top[i]  = shr[i][ACC_W-1:DW-1];
      if ((&top[i]) || !(|top[i]))
        res[i] = shr[i][DW-1:0];
      else if (shr[i][ACC_W-1])
        res[i] = SMIN;
      else
        res[i] = SMAX;
`ifdef PRO_ELE_RELU_EN
      if (res[i][DW-1]) res[i] = '0;
`endif
    end
  end

  // Count, accumulate and result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      fin_cnt <= '0;
      cnt     <= '0;
      pe_out  <= '0;
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (head) begin
            fin_cnt <= x_in[CNT_W-1:0];
            cnt     <= '0;
            for (int i = 0; i < LANES; i++) acc[i] <= '0;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            cnt <= cnt_inc;
            for (int i = 0; i < LANES; i++)
              acc[i] <= acc[i]
                      + {{(ACC_W-2*DW){prod[i][2*DW-1]}}, prod[i]};
          end
        end
        BIAS: begin
          for (int i = 0; i < LANES; i++)
            pe_out[i*DW +: DW] <= res[i];
        end
        DONE: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pro_ele_array.sv
// tb_pro_ele_array: random + directed jobs, queue scoreboard.
// Reference model uses plain integer arithmetic per lane.
module tb_pro_ele_array;

  localparam int DW    = 16;
  localparam int FRAC  = 8;
  localparam int LANES = 4;
  localparam int VW    = LANES*DW;

  logic          clock;
  logic          reset;
  logic          head;
  logic          head_stim;
  logic          head_mon;
  logic          in_valid;
  logic [DW-1:0] x_in;
  logic [VW-1:0] w;
  logic [VW-1:0] b;
  logic          out_ready;
  logic [VW-1:0] pe_out;
  logic          done_flag;
  logic          busy;

  assign head = head_stim | head_mon;

  pro_ele_array dut (
    .clock     (clock),
    .reset     (reset),
    .head      (head),
    .in_valid  (in_valid),
    .x_in      (x_in),
    .w         (w),
    .b         (b),
    .out_ready (out_ready),
    .pe_out    (pe_out),
    .done_flag (done_flag),
    .busy      (busy)
  );

  typedef struct {
    logic [VW-1:0] res;
    int            done_at;
    int            hold;
    bit            hack;
  } item_t;

  item_t q[$];
  bit    sink_busy;
  int    cyc = 0;
  int    errors = 0;
  int    checks = 0;

  logic [DW-1:0] xv [64];
  logic [DW-1:0] wv [64][LANES];
  logic [DW-1:0] bv [LANES];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: no finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Real-number semantics: sum x*w (Q16) + b*2^FRAC, floor, clamp
  function automatic logic [VW-1:0] model(input int n);
    logic [VW-1:0] r;
    longint unit;
    longint s;
    longint qq;
    longint hi;
    longint lo;
    unit = longint'(1) << FRAC;
    hi   = (longint'(1) << (DW-1)) - 1;
    lo   = -(longint'(1) << (DW-1));
    r    = '0;
    for (int l = 0; l < LANES; l++) begin
      s = longint'($signed(bv[l])) * unit;
      for (int k = 0; k < n; k++)
        s += longint'($signed(xv[k])) * longint'($signed(wv[k][l]));
      qq = s / unit;
      if (s < 0 && (s % unit) != 0) qq = qq - 1;
      if (qq > hi) qq = hi;
      if (qq < lo) qq = lo;
`ifdef PRO_ELE_RELU_EN
      if (qq < 0) qq = 0;
`endif
      r[l*DW +: DW] = DW'(qq);
    end
    return r;
  endfunction

  task automatic fill(input int n, input logic [DW-1:0] xx,
                      input logic [DW-1:0] ww, input logic [DW-1:0] bb);
    for (int k = 0; k < n; k++) begin
      xv[k] = xx;
      for (int l = 0; l < LANES; l++) wv[k][l] = ww;
    end
    for (int l = 0; l < LANES; l++) bv[l] = bb;
  endtask

  task automatic fill_rand(input int n, input bit big);
    for (int k = 0; k < n; k++) begin
      xv[k] = big ? DW'($urandom) : DW'($signed($urandom_range(0, 1023)) - 512);
      for (int l = 0; l < LANES; l++)
        wv[k][l] = big ? DW'($urandom) : DW'($signed($urandom_range(0, 1023)) - 512);
    end
    for (int l = 0; l < LANES; l++)
      bv[l] = big ? DW'($urandom) : DW'($signed($urandom_range(0, 2047)) - 1024);
  endtask

  task automatic job(input int n, input int gap, input int hold,
                     input bit hack, input int abort_at);
    item_t it;
    int    t;
    @(negedge clock);
    for (int l = 0; l < LANES; l++) b[l*DW +: DW] = bv[l];
    head_stim = 1'b1;
    x_in      = DW'(n);
    in_valid  = 1'b1;
    w         = {$urandom, $urandom};
    @(negedge clock);
    head_stim = 1'b0;
    in_valid  = 1'b0;
    for (int k = 0; k < n; k++) begin
      repeat (gap) begin
        x_in     = DW'($urandom);
        w        = {$urandom, $urandom};
        in_valid = 1'b0;
        @(negedge clock);
      end
      x_in = xv[k];
      for (int l = 0; l < LANES; l++) w[l*DW +: DW] = wv[k][l];
      in_valid  = 1'b1;
      head_stim = 1'($urandom);
      @(negedge clock);
      in_valid  = 1'b0;
      head_stim = 1'b0;
      if (k + 1 == abort_at) begin
        reset = 1'b1;
        @(negedge clock);
        chk("abort_out", 64'(pe_out), 64'd0);
        chk("abort_done", 64'(done_flag), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        return;
      end
    end
    x_in       = DW'(3);
    it.res     = model(n);
    it.done_at = cyc + 1;
    it.hold    = hold;
    it.hack    = hack;
    q.push_back(it);
    t = 0;
    while ((q.size() != 0 || sink_busy) && t < 300) begin
      @(negedge clock);
      t++;
    end
    checks++;
    if (t >= 300) begin
      errors++;
      $display("FAIL done_timeout: got %0d cycles want <300", t);
      q.delete();
    end
  endtask

  // Monitor: pops expectations on done_flag and runs the handshake
  initial begin
    item_t         e;
    logic [VW-1:0] snap;
    out_ready = 1'b0;
    head_mon  = 1'b0;
    sink_busy = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset && done_flag) begin
        sink_busy = 1'b1;
        if (q.size() == 0) begin
          chk("spurious_done", 64'(done_flag), 64'd0);
        end else begin
          e = q.pop_front();
          chk("pe_out", 64'(pe_out), 64'(e.res));
          chk("latency", 64'(cyc), 64'(e.done_at));
          chk("busy_done", 64'(busy), 64'd1);
          snap = pe_out;
          for (int k = 0; k < e.hold; k++) begin
            @(negedge clock);
            chk("hold_done", 64'(done_flag), 64'd1);
            chk("hold_out", 64'(pe_out), 64'(snap));
          end
          out_ready = 1'b1;
          head_mon  = e.hack;
          @(negedge clock);
          out_ready = 1'b0;
          head_mon  = 1'b0;
          chk("ack_done", 64'(done_flag), 64'd0);
          chk("ack_out", 64'(pe_out), 64'(snap));
          chk("ack_idle", 64'(busy), 64'd0);
        end
        sink_busy = 1'b0;
      end
    end
  end

  initial begin
    reset     = 1'b1;
    head_stim = 1'b0;
    in_valid  = 1'b0;
    x_in      = '0;
    w         = '0;
    b         = '0;
    repeat (2) @(negedge clock);
    chk("rst_out", 64'(pe_out), 64'd0);
    chk("rst_done", 64'(done_flag), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;

    fill(9, 16'h0040, 16'h0080, 16'h0100);
    job(9, 0, 1, 1'b0, -1);
    fill(4, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    job(4, 0, 0, 1'b1, -1);
    fill(4, 16'h7FFF, 16'h8000, 16'h7FFF);
    job(4, 1, 2, 1'b0, -1);
    fill(0, 16'h0, 16'h0, 16'h0);
    bv[0] = 16'h0100;
    bv[1] = 16'hFF00;
    bv[2] = 16'h0000;
    bv[3] = 16'h7FFF;
    job(0, 0, 1, 1'b1, -1);
    fill(1, 16'h0100, 16'hFE00, 16'h0000);
    job(1, 0, 0, 1'b0, -1);
    fill_rand(3, 1'b0);
    job(3, 0, 0, 1'b0, -1);
    job(3, 2, 5, 1'b1, -1);
    fill_rand(5, 1'b0);
    job(5, 0, 0, 1'b0, 2);
    fill(2, 16'h0100, 16'h0100, 16'h0000);
    job(2, 0, 0, 1'b0, -1);

    for (int j = 0; j < 25; j++) begin
      int n;
      n = $urandom_range(0, 12);
      fill_rand(n, 1'($urandom));
      job(n, $urandom_range(0, 2), $urandom_range(0, 3),
          1'($urandom), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pro_ele_array.md
PRO_ELE_ARRAY -- requirements
Module: pro_ele_array

Interface
REQ-001 Parameters SHALL be as follows, one per line.
- DW, 16, signed fixed-point data width of x, w, b and outputs.
- FRAC, 8, fractional bits of every data word.
- LANES, 4, number of parallel neuron lanes sharing one x stream.
- CNT_W, 10, width of the sample count loaded by the header.
- ACC_W, 2*DW+CNT_W, signed accumulator width per lane.

REQ-002 Ports SHALL be as follows, one per line.
- clock, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- head, input, 1: header strobe; x_in[CNT_W-1:0] carries final_count.
- in_valid, input, 1: x_in and w hold a valid sample this cycle.
- x_in, input, DW: shared activation broadcast to all lanes.
- w, input, LANES*DW: per-lane weights, with lane i at [i*DW +: DW].
- b, input, LANES*DW: per-lane biases, sampled in BIAS state.
- out_ready, input, 1: consumer accepts the result.
- pe_out, output, LANES*DW: per-lane results, registered.
- done_flag, output, 1: pe_out is valid.
- busy, output, 1: high in every state except IDLE.

Function
REQ-003 The FSM SHALL have the states IDLE, ACCUM, BIAS and DONE, and SHALL reset to IDLE.
REQ-004 In IDLE, head=1 SHALL load final_count from x_in[CNT_W-1:0] and clear all accumulators and the sample counter.
REQ-005 After the header, the FSM SHALL enter ACCUM if final_count is nonzero, and BIAS if final_count is zero.
REQ-006 In IDLE, in_valid SHALL be ignored.
REQ-007 In ACCUM, each cycle with in_valid=1 SHALL add sext(x_in*w_i) to acc_i for every lane and increment the counter.
REQ-008 In ACCUM, cycles with in_valid=0 SHALL hold all state unchanged.
REQ-009 In ACCUM, head SHALL be ignored.
REQ-010 When the counter reaches final_count, the FSM SHALL move to BIAS on the same edge that accepts the last sample.
REQ-011 BIAS SHALL last one cycle and compute r_i = (acc_i + (sext(b_i) << FRAC)) >>> FRAC, using an arithmetic shift that floors.
REQ-012 r_i SHALL be saturated to the signed DW range [-2^(DW-1), 2^(DW-1)-1] and registered into pe_out lane i.
REQ-013 The FSM SHALL enter DONE after BIAS, and done_flag SHALL be high in DONE only.
REQ-014 Latency SHALL be fixed: done_flag rises 2 edges after the edge that accepts the last sample.
REQ-015 With final_count=0, done_flag SHALL rise 2 edges after the header edge, and pe_out SHALL equal sat(b).
REQ-016 In DONE, pe_out and done_flag SHALL hold until out_ready=1.
REQ-017 The edge with out_ready=1 in DONE SHALL return the FSM to IDLE, clearing done_flag while pe_out keeps its value.
REQ-018 head arriving in the DONE cycle that completes the handshake SHALL be ignored; a new header is accepted only in IDLE.
REQ-019 The accumulator SHALL not overflow for final_count up to 2^CNT_W-1, so no intermediate wrap is permitted.

Reset
REQ-020 When reset=1 at an edge, the FSM SHALL go to IDLE and clear final_count, the counter, all acc_i, pe_out, done_flag and busy to 0.
REQ-021 Reset SHALL take priority over head, in_valid and out_ready in every state, including mid-ACCUM and DONE.

Configuration
REQ-022 With macro PRO_ELE_RELU_EN defined, the BIAS stage SHALL clamp negative saturated results to 0 before registering them into pe_out.
REQ-023 Without PRO_ELE_RELU_EN, pe_out SHALL carry the signed saturated result unchanged, and no ReLU logic SHALL be present.

Verification
All scenarios use defaults DW=16, FRAC=8 and LANES=4.
REQ-024 Header 9, then 9 samples with x=0x0040 (0.25), w=0x0080 (0.5) on all lanes and b=0x0100: every lane SHALL give 0x0220 (2.125), with done_flag 2 edges after the 9th sample.
REQ-025 Header 4, then x=0x7FFF, w=0x7FFF and b=0x7FFF: every lane SHALL give 0x7FFF (saturated); with w=0x8000 every lane SHALL give 0x8000.
REQ-026 Header 0 with b lanes 0x0100, 0xFF00, 0x0000, 0x7FFF: pe_out SHALL equal those values, with done_flag 2 edges after the header.
REQ-027 Header 1, x=0x0100, w=0xFE00 (-2.0), b=0: the result SHALL be 0xFE00 without PRO_ELE_RELU_EN and 0x0000 with it.
REQ-028 Header 3 with in_valid gaps of 2 cycles, then out_ready held low 5 cycles: the result SHALL equal the gap-free run, and done_flag and pe_out SHALL hold stable until out_ready rises, then done_flag falls on the next edge.
REQ-029 Reset asserted after 2 of 5 samples, then header 2 with x=0x0100, w=0x0100, b=0: the result SHALL be 0x0200, with no residue from the aborted run.
